// File: rtl/matrix_uart_loader.sv
// Front-end for the 3x3 8-bit matrix multiplier: collects 18 UART bytes into A/B,
// runs the multiplier, then streams the 9 result bytes out over a valid/ready port.
module matrix_uart_loader #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [71:0] mm_A,
  output logic [71:0] mm_B,
  output logic        mm_enable,
  output logic        mm_clear,
  input  logic [71:0] mm_C,
  input  logic        mm_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        rx_timeout,
  output logic        rx_overrun
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state;
  logic [4:0]      cnt;
  logic [3:0]      idx;
  logic [TO_W-1:0] to_cnt;
  logic [71:0]     result;
  logic [7:0]      tx_byte;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      cnt        <= 5'd0;
      idx        <= 4'd0;
      to_cnt     <= '0;
      result     <= 72'd0;
      mm_A       <= 72'd0;
      mm_B       <= 72'd0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      case (state)
        S_CLEAR: state <= S_RECV;
        S_RECV: begin
          if (rx_valid) begin
            // Bytes 0-8 fill A row-major, bytes 9-17 fill B the same way.
            for (int n = 0; n < 9; n++) begin
              if (cnt == 5'(n))     mm_A[n*8 +: 8] <= rx_data;
              if (cnt == 5'(n + 9)) mm_B[n*8 +: 8] <= rx_data;
            end
            to_cnt <= '0;
            if (cnt == 5'd17) begin
              cnt   <= 5'd0;
              state <= S_RUN;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end else if (cnt != 5'd0) begin
            if (to_cnt == TO_LAST) begin
              rx_timeout <= 1'b1;
              cnt        <= 5'd0;
              to_cnt     <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
          end
        end
        S_RUN: begin
          if (mm_done) begin
            result <= mm_C;
            idx    <= 4'd0;
            state  <= S_SEND;
          end
        end
        default: begin
          // Handshake: a byte moves on any rising edge where tx_valid and
          // tx_ready are both high; tx_valid/tx_data never change otherwise.
          if (tx_ready) begin
            if (idx == 4'd8) begin
              idx   <= 4'd0;
              state <= S_CLEAR;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    for (int n = 0; n < 9; n++) begin
      if (idx == 4'(n)) tx_byte = result[n*8 +: 8];
    end
  end

  assign mm_clear   = (state == S_CLEAR);
  assign mm_enable  = (state == S_RUN);
  assign tx_valid   = (state == S_SEND);
  assign tx_data    = tx_valid ? tx_byte : 8'h00;
  assign busy       = (state == S_RUN) || (state == S_SEND);
  assign rx_overrun = rx_valid && (state != S_RECV) && !reset;

endmodule

// File: doc/matrix_uart_loader.md
Name: matrix_uart_loader

Overview:
- Front-end controller between the UART byte link and the 3x3 8-bit matrix multiplier.
- Assembles 18 received bytes into the multiplier's 72-bit A and B operands.
- Drives the multiplier's Enable and reset, waits for done, captures the 72-bit result C, and streams it out as 9 bytes over a valid/ready transmit interface.
- Sequences one job after another indefinitely.

Parameters:
- TIMEOUT_CYCLES, 100000: idle cycles between bytes after which a partially received frame is discarded.
- TO_W, 17: width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- Clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- mm_A  out  72  operand A; element n=i*3+j at bits [n*8+:8]
- mm_B  out  72  operand B, same packing
- mm_enable  out  1  multiplier Enable
- mm_clear  out  1  multiplier reset (active-high)
- mm_C  in  72  multiplier result, same packing
- mm_done  in  1  multiplier done
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte; transfer occurs when tx_valid and tx_ready are both high
- busy  out  1  high in RUN and SEND
- rx_timeout  out  1  one-cycle pulse: partial frame discarded
- rx_overrun  out  1  one-cycle pulse: byte dropped because not in RECV

Behaviour:
- Clock is Clock; reset is reset, asynchronous, active-high.
- Reset values:
  - Outputs: mm_A=0, mm_B=0, mm_enable=0, tx_data=0, tx_valid=0, busy=0, rx_timeout=0, rx_overrun=0, mm_clear=1.
  - Internal: state=CLEAR, byte count=0, tx index=0, timeout counter=0.
- FSM states CLEAR, RECV, RUN, SEND:
  - CLEAR: mm_clear=1 for exactly one cycle, mm_enable=0; next state RECV. mm_clear=0 in every other state.
  - RECV:
    - Each cycle with rx_valid=1 stores rx_data at byte index cnt (0..17). Indices 0-8 go to mm_A[cnt*8+:8]; indices 9-17 go to mm_B[(cnt-9)*8+:8]. cnt then increments.
    - The first received byte lands in mm_A[7:0] (element A[0][0]).
    - Acceptance of byte 17 moves to RUN next cycle, with cnt reset to 0.
  - RUN:
    - mm_enable=1 from the first RUN cycle and held continuously.
    - mm_A and mm_B are held stable from RUN entry until the next CLEAR.
    - On a cycle sampling mm_done=1, mm_C is captured into an internal result register, state becomes SEND, mm_enable=0 from the next cycle, and tx index=0.
    - No timeout in RUN.
  - SEND:
    - tx_valid=1; tx_data=result[idx*8+:8].
    - On tx_valid & tx_ready, idx increments and the next byte is presented in the following cycle with no bubble.
    - While tx_ready=0, tx_valid and tx_data hold stable.
    - Transfer of idx 8 moves to CLEAR, with tx_valid=0 from the next cycle.
- Inter-byte timeout:
  - Active only in RECV with cnt>0.
  - Counter increments on each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES: rx_timeout pulses 1 cycle, cnt=0, counter=0, and state remains RECV. Already-written mm_A/mm_B bits are don't-care.
  - If rx_valid arrives on the same cycle as expiry, the byte wins: it is stored and there is no timeout.
  - Counter is held at 0 when cnt==0.
- rx_valid in CLEAR, RUN or SEND: byte dropped, rx_overrun pulses that cycle, no state change.
- mm_done while not in RUN: ignored.
- Result bytes are transmitted in order C element 0..8, i.e. row-major C[0][0] first.
- Asynchronous reset mid-operation: immediate return to reset values, the partial frame and any pending result are lost, and the one-cycle CLEAR pulse follows the first clock edge after reset release.

Test Plan:
- Functional: A=identity (bytes 01,00,00,00,01,00,00,00,01), B bytes 01..09 -> mm_A=72'h010000000100000001 with mm_A[7:0]=01; tx bytes 01,02,...,09 in order; then mm_clear pulse; busy low after last transfer.
- Wrap and back-to-back: job 1 all A=02, all B=03 -> nine bytes 0x12. Job 2 immediately after, all A=10h, all B=10h -> nine bytes 0x00 (mod-256 wrap). mm_clear pulses once between jobs.
- Timeout (TIMEOUT_CYCLES=50): send 5 bytes then idle 50 cycles -> rx_timeout single pulse, no RUN entry; then a full 18-byte frame -> correct result.
- Backpressure: hold tx_ready=0 for 20 cycles at SEND entry -> tx_valid=1 and tx_data=byte 0 stable throughout; release gives 9 transfers in 9 consecutive cycles.
- Overrun: inject rx_valid with 0xFF during RUN -> rx_overrun 1-cycle pulse; mm_A/mm_B unchanged; result unaffected.
- Reset mid-RECV after 10 bytes -> all outputs at reset values while reset is high; mm_clear pulse after release; a fresh 18-byte frame yields the correct result.
